// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns a latched load/store into a registered dcache
// request, holds it until dhit, and drives the MEM/WB memory inputs, the
// pipeline stall, sticky halt and a sticky watchdog timeout.
module mem_stage_ctrl #(
  parameter int unsigned MAX_WAIT = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             exmem_valid,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic [31:0]      exmem_addr,
  input  logic [31:0]      exmem_store,
  input  logic             exmem_halt,
  input  logic             flush,
  input  logic             dhit,
  input  logic [31:0]      dmemload,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic [31:0]      dmemaddr,
  output logic [31:0]      dmemstore,
  output logic [31:0]      dload_o,
  output logic             memory_en,
  output logic             mem_stall,
  output logic             halt_o,
  output logic             timeout,
  output logic [CNT_W-1:0] access_cnt
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StHalt} state_e;

  state_e             r_state, w_state_d;
  logic               r_ren, w_ren_d;
  logic               r_wen, w_wen_d;
  logic [31:0]        r_addr, w_addr_d;
  logic [31:0]        r_store, w_store_d;
  logic [31:0]        r_dload, w_dload_d;
  logic [WaitW-1:0]   r_wait, w_wait_d;
  logic               r_squash, w_squash_d;
  logic               r_halt, w_halt_d;
  logic               r_timeout, w_timeout_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               w_squash_now;
  logic               w_mem_en;
  logic               w_stall;
  logic [31:0]        w_dload;

  // Next-state and combinational outputs for the access FSM.
  always_comb begin
    w_state_d    = r_state;
    w_ren_d      = r_ren;
    w_wen_d      = r_wen;
    w_addr_d     = r_addr;
    w_store_d    = r_store;
    w_dload_d    = r_dload;
    w_wait_d     = r_wait;
    w_squash_d   = r_squash;
    w_halt_d     = r_halt;
    w_timeout_d  = r_timeout;
    w_cnt_d      = r_cnt;
    w_squash_now = r_squash | flush;
    w_mem_en     = 1'b0;
    w_stall      = 1'b0;
    w_dload      = r_dload;

    unique case (r_state)
      StIdle: begin
        if (exmem_valid && !flush) begin
          if (exmem_halt) begin
            // HALT wins over any memory op carried by the same instruction.
            w_mem_en  = 1'b1;
            w_halt_d  = 1'b1;
            w_state_d = StHalt;
          end else if (exmem_dREN || exmem_dWEN) begin
            w_stall    = 1'b1;
            w_addr_d   = exmem_addr;
            w_store_d  = exmem_store;
            w_wen_d    = exmem_dWEN;
            w_ren_d    = exmem_dREN && !exmem_dWEN;
            w_wait_d   = '0;
            w_squash_d = 1'b0;
            w_state_d  = StWait;
          end else begin
            w_mem_en = 1'b1;
          end
        end
      end
      StWait: begin
        if (dhit) begin
          // The bus transaction always completes; squash only hides it.
          w_ren_d    = 1'b0;
          w_wen_d    = 1'b0;
          w_squash_d = 1'b0;
          w_wait_d   = '0;
          w_state_d  = StIdle;
          if (!w_squash_now) begin
            w_mem_en = 1'b1;
            w_cnt_d  = r_cnt + 1'b1;
          end
          if (r_ren) begin
            w_dload   = dmemload;
            w_dload_d = dmemload;
          end
        end else begin
          w_stall    = 1'b1;
          w_squash_d = w_squash_now;
          if (r_wait != WaitW'(MAX_WAIT)) begin
            w_wait_d = r_wait + 1'b1;
            if (w_wait_d == WaitW'(MAX_WAIT)) begin
              w_timeout_d = 1'b1;
            end
          end
        end
      end
      StHalt: begin
        w_ren_d = 1'b0;
        w_wen_d = 1'b0;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= StIdle;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
      r_dload   <= '0;
      r_wait    <= '0;
      r_squash  <= 1'b0;
      r_halt    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_ren     <= w_ren_d;
      r_wen     <= w_wen_d;
      r_addr    <= w_addr_d;
      r_store   <= w_store_d;
      r_dload   <= w_dload_d;
      r_wait    <= w_wait_d;
      r_squash  <= w_squash_d;
      r_halt    <= w_halt_d;
      r_timeout <= w_timeout_d;
      r_cnt     <= w_cnt_d;
    end
  end

  assign dmemREN    = r_ren;
  assign dmemWEN    = r_wen;
  assign dmemaddr   = r_addr;
  assign dmemstore  = r_store;
  assign dload_o    = w_dload;
  assign memory_en  = w_mem_en;
  assign mem_stall  = w_stall;
  assign halt_o     = r_halt;
  assign timeout    = r_timeout;
  assign access_cnt = r_cnt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid, exmem_dren, exmem_dwen, exmem_halt;
  logic [31:0] exmem_addr, exmem_store;
  logic        flush, dhit;
  logic [31:0] dmemload;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_addr, dmem_store, dload;
  logic        memory_en, mem_stall, halt, timeout;
  logic [15:0] access_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .MAX_WAIT (4),
    .CNT_W    (16)
  ) u_dut (
    .CLK         (clk),
    .RST         (rst),
    .exmem_valid (exmem_valid),
    .exmem_dREN  (exmem_dren),
    .exmem_dWEN  (exmem_dwen),
    .exmem_addr  (exmem_addr),
    .exmem_store (exmem_store),
    .exmem_halt  (exmem_halt),
    .flush       (flush),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .dmemREN     (dmem_ren),
    .dmemWEN     (dmem_wen),
    .dmemaddr    (dmem_addr),
    .dmemstore   (dmem_store),
    .dload_o     (dload),
    .memory_en   (memory_en),
    .mem_stall   (mem_stall),
    .halt_o      (halt),
    .timeout     (timeout),
    .access_cnt  (access_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    exmem_valid = 1'b0; exmem_dren = 1'b0; exmem_dwen = 1'b0; exmem_halt = 1'b0;
    exmem_addr  = '0;   exmem_store = '0;  flush = 1'b0;      dhit = 1'b0;
    dmemload    = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    sample();
    check("rst_ren", 32'(dmem_ren), 0);
    check("rst_wen", 32'(dmem_wen), 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_store", dmem_store, 0);
    check("rst_dload", dload, 0);
    check("rst_men", 32'(memory_en), 0);
    check("rst_stall", 32'(mem_stall), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_tmo", 32'(timeout), 0);
    check("rst_cnt", 32'(access_cnt), 0);
    tick();

    // Load hit at cycle 3
    exmem_valid = 1'b1; exmem_dren = 1'b1; exmem_addr = 32'h100;
    sample();
    check("ld_c0_stall", 32'(mem_stall), 1);
    check("ld_c0_men", 32'(memory_en), 0);
    check("ld_c0_ren", 32'(dmem_ren), 0);
    tick();
    clear_inputs();
    sample();
    check("ld_c1_ren", 32'(dmem_ren), 1);
    check("ld_c1_addr", dmem_addr, 32'h100);
    check("ld_c1_stall", 32'(mem_stall), 1);
    tick();
    sample();
    check("ld_c2_ren", 32'(dmem_ren), 1);
    check("ld_c2_stall", 32'(mem_stall), 1);
    tick();
    dhit = 1'b1; dmemload = 32'hDEADBEEF;
    sample();
    check("ld_c3_ren", 32'(dmem_ren), 1);
    check("ld_c3_stall", 32'(mem_stall), 0);
    check("ld_c3_men", 32'(memory_en), 1);
    check("ld_c3_dload", dload, 32'hDEADBEEF);
    tick();
    clear_inputs();
    sample();
    check("ld_c4_ren", 32'(dmem_ren), 0);
    check("ld_c4_men", 32'(memory_en), 0);
    check("ld_c4_cnt", 32'(access_cnt), 1);
    check("ld_c4_dload", dload, 32'hDEADBEEF);
    tick();

    // Store, immediate hit
    exmem_valid = 1'b1; exmem_dwen = 1'b1; exmem_addr = 32'h200; exmem_store = 32'h12345678;
    sample();
    check("st_c0_stall", 32'(mem_stall), 1);
    tick();
    clear_inputs();
    dhit = 1'b1; dmemload = 32'hAAAA5555;
    sample();
    check("st_c1_wen", 32'(dmem_wen), 1);
    check("st_c1_ren", 32'(dmem_ren), 0);
    check("st_c1_addr", dmem_addr, 32'h200);
    check("st_c1_data", dmem_store, 32'h12345678);
    check("st_c1_men", 32'(memory_en), 1);
    check("st_c1_stall", 32'(mem_stall), 0);
    check("st_c1_dload", dload, 32'hDEADBEEF);
    tick();
    clear_inputs();
    sample();
    check("st_c2_wen", 32'(dmem_wen), 0);
    check("st_c2_men", 32'(memory_en), 0);
    check("st_c2_cnt", 32'(access_cnt), 2);
    check("st_c2_dload", dload, 32'hDEADBEEF);
    tick();

    // Flush at WAIT cycle 2, dhit at cycle 4
    exmem_valid = 1'b1; exmem_dren = 1'b1; exmem_addr = 32'h300;
    tick();
    clear_inputs();
    tick();
    flush = 1'b1;
    sample();
    check("fl_c2_ren", 32'(dmem_ren), 1);
    check("fl_c2_men", 32'(memory_en), 0);
    tick();
    flush = 1'b0;
    sample();
    check("fl_c3_ren", 32'(dmem_ren), 1);
    tick();
    dhit = 1'b1; dmemload = 32'h11112222;
    sample();
    check("fl_c4_ren", 32'(dmem_ren), 1);
    check("fl_c4_men", 32'(memory_en), 0);
    check("fl_c4_stall", 32'(mem_stall), 0);
    tick();
    clear_inputs();
    sample();
    check("fl_c5_ren", 32'(dmem_ren), 0);
    check("fl_c5_cnt", 32'(access_cnt), 2);
    tick();

    // Watchdog: 10 WAIT cycles without dhit, MAX_WAIT = 4
    exmem_valid = 1'b1; exmem_dren = 1'b1; exmem_addr = 32'h400;
    tick();
    clear_inputs();
    for (int i = 1; i <= 10; i++) begin
      sample();
      check($sformatf("wd_c%0d_tmo", i), 32'(timeout), (i >= 5) ? 32'd1 : 32'd0);
      check($sformatf("wd_c%0d_stall", i), 32'(mem_stall), 1);
      tick();
    end
    dhit = 1'b1; dmemload = 32'h00000055;
    sample();
    check("wd_hit_men", 32'(memory_en), 1);
    check("wd_hit_dload", dload, 32'h55);
    tick();
    clear_inputs();
    sample();
    check("wd_after_tmo", 32'(timeout), 1);
    check("wd_after_cnt", 32'(access_cnt), 3);
    check("wd_after_ren", 32'(dmem_ren), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("wd_rst_tmo", 32'(timeout), 0);
    check("wd_rst_cnt", 32'(access_cnt), 0);
    check("wd_rst_dload", dload, 0);
    tick();

    // Both dREN and dWEN: store wins; then reset mid-WAIT
    exmem_valid = 1'b1; exmem_dren = 1'b1; exmem_dwen = 1'b1;
    exmem_addr = 32'h500; exmem_store = 32'hCAFEF00D;
    tick();
    clear_inputs();
    sample();
    check("both_wen", 32'(dmem_wen), 1);
    check("both_ren", 32'(dmem_ren), 0);
    check("both_data", dmem_store, 32'hCAFEF00D);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("rstw_wen", 32'(dmem_wen), 0);
    check("rstw_ren", 32'(dmem_ren), 0);
    check("rstw_stall", 32'(mem_stall), 0);
    check("rstw_cnt", 32'(access_cnt), 0);
    tick();

    // Flush in IDLE blocks a memory op
    exmem_valid = 1'b1; exmem_dren = 1'b1; exmem_addr = 32'h600; flush = 1'b1;
    sample();
    check("ifl_men", 32'(memory_en), 0);
    check("ifl_stall", 32'(mem_stall), 0);
    tick();
    clear_inputs();
    sample();
    check("ifl_ren", 32'(dmem_ren), 0);
    tick();

    // ALU op, then HALT, then a load that must be ignored
    exmem_valid = 1'b1;
    sample();
    check("alu_men", 32'(memory_en), 1);
    check("alu_stall", 32'(mem_stall), 0);
    tick();
    exmem_halt = 1'b1;
    sample();
    check("hlt_men", 32'(memory_en), 1);
    check("hlt_halt_pre", 32'(halt), 0);
    tick();
    exmem_halt = 1'b0; exmem_dren = 1'b1; exmem_addr = 32'h700;
    sample();
    check("hlt_halt", 32'(halt), 1);
    check("hlt_ld_men", 32'(memory_en), 0);
    check("hlt_ld_stall", 32'(mem_stall), 0);
    tick();
    sample();
    check("hlt_ld_ren", 32'(dmem_ren), 0);
    check("hlt_halt2", 32'(halt), 1);
    tick();
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
